// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register pending scoreboard
// and a clear FSM that zeroes the array after reset.
// Ports: clk, rst (sync, active-high); raddr_i/rdata_o/rbusy_o read ports;
// waddr_i/wdata_i/we_i write ports; rsv_i/rsv_addr_i reservation;
// ready_o high once the clear sequence has finished.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT),
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]   raddr_i,
    output logic [NUM_READ*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_READ-1:0]              rbusy_o,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  waddr_i,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wdata_i,
    input  logic [NUM_WRITE-1:0]             we_i,
    input  logic                             rsv_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    output logic                             ready_o
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_COUNT - 1);

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_n;
    logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
    logic [REG_COUNT-1:0]    pend;

    logic [ADDR_WIDTH-1:0]   ra [NUM_READ];
    logic [ADDR_WIDTH-1:0]   wa [NUM_WRITE];
    logic [DATA_WIDTH-1:0]   wd [NUM_WRITE];
    logic [NUM_WRITE-1:0]    wacc;
    logic                    rsv_acc;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        assign ra[k] = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end

    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr
        assign wa[j]   = waddr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd[j]   = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        assign wacc[j] = ready_o && we_i[j] && (wa[j] != '0);
    end

    // Gating with rst drops ready in the same cycle reset is raised.
    assign ready_o = (state == READY) && !rst;
    assign rsv_acc = ready_o && rsv_i && (rsv_addr_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= ADDR_WIDTH'(1);
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            CLEAR: begin
                if (cnt == LAST) state_n = READY;
                else             cnt_n   = cnt + 1'b1;
            end
            READY: ;
            default: state_n = CLEAR;
        endcase
    end

    // Array has no reset; the CLEAR walk zeroes it one entry per cycle.
    // Later loop iterations override earlier ones: highest port wins.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wacc[j]) regs[wa[j]] <= wd[j];
            end
        end
    end

    // Reservation is applied after write clears so it wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            for (int j = 0; j < NUM_WRITE; j++) begin
                if (wacc[j]) pend[wa[j]] <= 1'b0;
            end
            if (rsv_acc) pend[rsv_addr_i] <= 1'b1;
        end
    end

    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            if (ready_o && (ra[k] != '0)) begin
                rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[ra[k]];
                rbusy_o[k] = pend[ra[k]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NUM_WRITE; j++) begin
                    if (wacc[j] && (wa[j] == ra[k])) begin
                        rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = wd[j];
                        rbusy_o[k] = rsv_acc && (rsv_addr_i == ra[k]);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table vectors, clear/reset sequences and random
// traffic checked against a behavioural model of regfile_mp.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic        ready;

    int checks = 0;
    int passes = 0;

    regfile_mp dut (
        .clk        (clk),
        .rst        (rst),
        .raddr_i    (raddr),
        .rdata_o    (rdata),
        .rbusy_o    (rbusy),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .we_i       (we),
        .rsv_i      (rsv),
        .rsv_addr_i (rsv_addr),
        .ready_o    (ready)
    );

    always #5 clk = ~clk;

    // Behavioural model: memory image, pending flags, cycles since reset.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    int          m_cnt = 0;

    function automatic bit m_rdy();
        return !rst && (m_cnt >= 31);
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        logic [31:0] v;
        if (!m_rdy() || a == 5'd0) return 32'd0;
        v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < 2; j++)
            if (we[j] && waddr[j*5 +: 5] == a) v = wdata[j*32 +: 32];
`endif
        return v;
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        logic b;
        if (!m_rdy() || a == 5'd0) return 1'b0;
        b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < 2; j++)
            if (we[j] && waddr[j*5 +: 5] == a) b = rsv && (rsv_addr == a);
`endif
        return b;
    endfunction

    task automatic model_edge();
        logic [4:0] a;
        if (rst) begin
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (m_cnt < 31) begin
            m_cnt++;
            if (m_cnt == 31)
                for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                a = waddr[j*5 +: 5];
                if (we[j] && a != 5'd0) begin
                    m_mem[a]  = wdata[j*32 +: 32];
                    m_pend[a] = 0;
                end
            end
            if (rsv && rsv_addr != 5'd0) m_pend[rsv_addr] = 1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic cmp_model();
        logic [4:0] a;
        #1;
        check("m_ready", 64'(ready), 64'(m_rdy()));
        for (int k = 0; k < 2; k++) begin
            a = raddr[k*5 +: 5];
            check("m_rdata", 64'(rdata[k*32 +: 32]), 64'(m_rd(a)));
            check("m_rbusy", 64'(rbusy[k]), 64'(m_busy(a)));
        end
    endtask

    task automatic drv(input logic [4:0] wa0, input logic [31:0] wd0,
                       input logic we0, input logic [4:0] wa1,
                       input logic [31:0] wd1, input logic we1,
                       input logic rs, input logic [4:0] rsa,
                       input logic [4:0] ra0, input logic [4:0] ra1);
        waddr    = {wa1, wa0};
        wdata    = {wd1, wd0};
        we       = {we1, we0};
        rsv      = rs;
        rsv_addr = rsa;
        raddr    = {ra1, ra0};
    endtask

    // Writes and reservations during CLEAR must be ignored.
    task automatic clear_seq();
        for (int k = 0; k <= 31; k++) begin
            drv(5'd4, $urandom, 1'b1, 5'd6, $urandom, 1'b1,
                1'b1, 5'd4, 5'($urandom), 5'($urandom));
            cmp_model();
            check("clr_ready", 64'(ready), 64'(k >= 31));
            if (k < 31) begin
                check("clr_rdata", rdata, 64'd0);
                tick();
            end
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd6);
        cmp_model();
        check("clr_wr_ign", rdata, 64'd0);
        check("clr_rsv_ign", 64'(rbusy), 64'd0);
    endtask

    typedef struct {
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        we1;
        logic        rs;
        logic [4:0]  rsa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t vt [8];

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        cmp_model();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_rdata", rdata, 64'd0);
        rst = 1'b0;
        clear_seq();

        vt[0] = '{5, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 5, 5,
                  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        vt[1] = '{0, 32'h1, 1, 0, 0, 0, 0, 0, 0, 5,
                  32'h0, 32'hDEADBEEF, 2'b00};
        vt[2] = '{7, 32'h11, 1, 7, 32'h22, 1, 0, 0, 7, 7,
                  32'h22, 32'h22, 2'b00};
        vt[3] = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 0,
                  32'h0, 32'h0, 2'b01};
        vt[4] = '{9, 32'h55, 1, 0, 0, 0, 0, 0, 9, 9,
                  32'h55, 32'h55, 2'b00};
        vt[5] = '{0, 0, 0, 9, 32'h66, 1, 1, 9, 9, 9,
                  32'h66, 32'h66, 2'b11};
        vt[6] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 9,
                  32'h0, 32'h66, 2'b10};
        vt[7] = '{1, 32'h12345678, 1, 31, 32'hFFFFFFFF, 1, 0, 0, 31, 1,
                  32'hFFFFFFFF, 32'h12345678, 2'b00};

        for (int i = 0; i < 8; i++) begin
            drv(vt[i].wa0, vt[i].wd0, vt[i].we0, vt[i].wa1, vt[i].wd1,
                vt[i].we1, vt[i].rs, vt[i].rsa, vt[i].ra0, vt[i].ra1);
            cmp_model();
            tick();
            drv(0, 0, 0, 0, 0, 0, 0, 0, vt[i].ra0, vt[i].ra1);
            cmp_model();
            check("vec_rd0", 64'(rdata[31:0]), 64'(vt[i].e0));
            check("vec_rd1", 64'(rdata[63:32]), 64'(vt[i].e1));
            check("vec_busy", 64'(rbusy), 64'(vt[i].eb));
            tick();
        end

        drv(5'd3, 32'h1234, 1, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        cmp_model();
        tick();
        drv(5'd3, 32'hCAFE, 1, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        cmp_model();
`ifdef REGFILE_BYPASS_EN
        check("byp_same", 64'(rdata[31:0]), 64'h0000CAFE);
`else
        check("byp_same", 64'(rdata[31:0]), 64'h00001234);
`endif
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        cmp_model();
        check("byp_after", 64'(rdata[31:0]), 64'h0000CAFE);
        tick();

        for (int n = 0; n < 300; n++) begin
            drv(5'($urandom_range(0, 7)), $urandom, 1'($urandom),
                5'($urandom_range(0, 7)), $urandom, 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            cmp_model();
            tick();
        end

        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd0);
        cmp_model();
        check("rst_mid_ready", 64'(ready), 64'd0);
        tick();
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cmp_model();
            tick();
        end
        rst = 1'b1;
        cmp_model();
        tick();
        rst = 1'b0;
        clear_seq();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd7);
        cmp_model();
        check("reclr_rdata", rdata, 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter REG_COUNT, default 32, number of architectural registers (power of two, >=4).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(REG_COUNT), register address width.
REQ-004 SHALL have parameter NUM_READ, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter NUM_WRITE, default 2, number of write ports (1..3).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port raddr_i  input  NUM_READ*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 SHALL have port rdata_o  output  NUM_READ*DATA_WIDTH  read data, same packing.
REQ-010 SHALL have port rbusy_o  output  NUM_READ  scoreboard pending flag of the register addressed by each read port.
REQ-011 SHALL have port waddr_i  input  NUM_WRITE*ADDR_WIDTH  write addresses, packed as raddr_i.
REQ-012 SHALL have port wdata_i  input  NUM_WRITE*DATA_WIDTH  write data.
REQ-013 SHALL have port we_i  input  NUM_WRITE  per-port write enable.
REQ-014 SHALL have port rsv_i  input  1  reserve request: mark register rsv_addr_i pending.
REQ-015 SHALL have port rsv_addr_i  input  ADDR_WIDTH  register to reserve.
REQ-016 SHALL have port ready_o  output  1  high when clear sequence done and block accepts traffic.

Function
REQ-017 SHALL implement reads combinationally: rdata_o port k = reg[raddr k], zero latency.
REQ-018 SHALL hardwire register 0: reads return 0, rbusy 0; writes and reservations to address 0 ignored.
REQ-019 SHALL perform a write on the rising edge when we_i[j]=1, addr!=0, ready_o=1; data visible on reads the next cycle.
REQ-020 SHALL resolve same-address writes in one cycle by highest port index winning.
REQ-021 SHALL hold one pending bit per register; rsv_i=1 with ready_o=1 sets bit rsv_addr_i next cycle.
REQ-022 SHALL clear a pending bit on any accepted write to that register.
REQ-023 SHALL, when reservation and write target the same register in one cycle, leave the bit set (reservation wins).
REQ-024 SHALL drive rbusy_o[k] combinationally from pending bit of raddr k.
REQ-025 SHALL contain a clear FSM with states CLEAR and READY; CLEAR walks a counter 1..REG_COUNT-1 zeroing one register per cycle, then enters READY.
REQ-026 SHALL, in CLEAR: ready_o=0, writes and reservations ignored, rdata_o all 0, rbusy_o all 0.
REQ-027 SHALL take exactly REG_COUNT-1 cycles after rst deassertion to assert ready_o; ready_o stays high until next rst.
REQ-028 SHALL restart the clear sequence from counter 1 if rst asserts mid-CLEAR.

Reset
REQ-029 SHALL, while rst=1, force FSM to CLEAR, counter to 1, all pending bits to 0, ready_o to 0.
REQ-030 SHALL not require reset of the register array itself; zeroing is done by the clear FSM.

Configuration
REQ-031 SHALL support macro REGFILE_BYPASS_EN: when defined, a read whose address matches an enabled same-cycle write (ready_o=1, addr!=0) returns that wdata (highest matching port), and rbusy_o for it reads 0 unless rsv_i targets the same address; when undefined, reads return the stored value only.

Verification
REQ-032 SHALL verify clear: rst 1 cycle, then ready_o=0 for 31 cycles, 1 on cycle 31 (REG_COUNT=32); all reads 0 throughout.
REQ-033 SHALL verify write/read: write 0xDEADBEEF to r5 port 0 -> next cycle both read ports at r5 return 0xDEADBEEF; write 0x1 to r0 -> r0 reads 0.
REQ-034 SHALL verify conflict: port0 writes 0x11, port1 writes 0x22 to r7 same cycle -> r7 reads 0x22.
REQ-035 SHALL verify scoreboard: rsv r9 -> rbusy 1 next cycle; write r9 -> rbusy 0 next cycle; rsv and write r9 same cycle -> rbusy stays 1.
REQ-036 SHALL verify bypass: write 0xCAFE to r3 while reading r3 -> with REGFILE_BYPASS_EN same-cycle rdata 0xCAFE; without, old value.
REQ-037 SHALL verify mid-clear reset: rst at clear cycle 10 -> ready_o asserts 31 cycles after second rst release; writes during CLEAR have no effect.
